mvm_uart_tx: RTL and testbench

- Transmit end of the MVM UART link: accepts one parallel result bus (R outputs of W_Y_OUT bits) over a valid/ready handshake.
- Serialises the bus as N_WORDS UART packets on a single tx line.
- Each packet: one start bit, BITS_PER_WORD data bits LSB first, then ones until the packet is PACKET_SIZE bits long.
- Sits between the MVM output register and the top-level uo_out[0] pin.

---
 rtl/mvm_uart_pkg.sv | 17 +
 rtl/mvm_uart_tx_if.sv | 13 +
 rtl/uart_baud_tick.sv | 36 +++
 rtl/mvm_uart_tx.sv | 109 ++++++++++
 tb/tb_mvm_uart_tx.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/mvm_uart_pkg.sv
// Shared constants and types for the MVM UART link (transmit and receive ends).
package mvm_uart_pkg;

  localparam int unsigned CLOCKS_PER_PULSE = 434;
  localparam int unsigned BITS_PER_WORD    = 8;
  localparam int unsigned PACKET_SIZE_TX   = BITS_PER_WORD + 5;
  localparam int unsigned R                = 2;
  localparam int unsigned W_Y_OUT          = 8;
  localparam int unsigned W_BUS_Y          = R * W_Y_OUT;
  localparam int unsigned N_WORDS_Y        = W_BUS_Y / BITS_PER_WORD;

  typedef enum logic {
    IDLE,
    SEND
  } tx_state_e;

endpackage

// File: rtl/mvm_uart_tx_if.sv
// Valid/ready stream carrying one MVM result bus into the UART transmitter.
interface mvm_uart_tx_if #(
  parameter int unsigned W_BUS = mvm_uart_pkg::W_BUS_Y
) ();

  logic             valid;
  logic             ready;
  logic [W_BUS-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: emits a one-cycle tick on the last cycle of every bit period.
module uart_baud_tick #(
  parameter int unsigned CLOCKS_PER_PULSE = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CntW = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLOCKS_PER_PULSE - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && !clr_i && (cnt_q == CntMax);

endmodule

// File: rtl/mvm_uart_tx.sv
// Serialises one MVM result bus into N_WORDS back-to-back UART packets on tx_o.
module mvm_uart_tx #(
  parameter int unsigned CLOCKS_PER_PULSE = mvm_uart_pkg::CLOCKS_PER_PULSE,
  parameter int unsigned BITS_PER_WORD    = mvm_uart_pkg::BITS_PER_WORD,
  parameter int unsigned PACKET_SIZE      = mvm_uart_pkg::PACKET_SIZE_TX,
  parameter int unsigned R                = mvm_uart_pkg::R,
  parameter int unsigned W_Y_OUT          = mvm_uart_pkg::W_Y_OUT
) (
  input  logic               clk,
  input  logic               rst,
  mvm_uart_tx_if.slave       s_if,
  output logic               tx_o,
  output logic               busy_o
);

  import mvm_uart_pkg::*;

  localparam int unsigned W_BUS   = R * W_Y_OUT;
  localparam int unsigned N_WORDS = W_BUS / BITS_PER_WORD;
  localparam int unsigned FrameW  = N_WORDS * PACKET_SIZE;
  localparam int unsigned BitCntW = $clog2(FrameW + 1);
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(FrameW - 1);

  if (W_BUS % BITS_PER_WORD != 0) begin : g_bad_bus
    $error("mvm_uart_tx: W_BUS must be a multiple of BITS_PER_WORD");
  end
  if (PACKET_SIZE < BITS_PER_WORD + 2) begin : g_bad_packet
    $error("mvm_uart_tx: PACKET_SIZE must hold start, data and at least one stop bit");
  end
  if (CLOCKS_PER_PULSE < 2) begin : g_bad_baud
    $error("mvm_uart_tx: CLOCKS_PER_PULSE must be at least 2");
  end

  tx_state_e           state_q;
  logic [FrameW-1:0]   shreg_q;
  logic [BitCntW-1:0]  bit_cnt_q;
  logic                tx_q;
  logic                ready_q;
  logic                busy_q;
  logic [FrameW-1:0]   frame;
  logic                accept;
  logic                tick;

  assign accept = s_if.valid && ready_q;

  // Whole transfer laid out low bit first: per word a start 0, data LSB first, then ones.
  always_comb begin
    frame = '1;
    for (int w = 0; w < N_WORDS; w++) begin
      frame[w*PACKET_SIZE] = 1'b0;
      frame[w*PACKET_SIZE+1 +: BITS_PER_WORD] = s_if.data[w*BITS_PER_WORD +: BITS_PER_WORD];
    end
  end

  uart_baud_tick #(
    .CLOCKS_PER_PULSE(CLOCKS_PER_PULSE)
  ) u_baud_tick (
    .clk   (clk),
    .rst   (rst),
    .clr_i (accept),
    .en_i  (state_q == SEND),
    .tick_o(tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '1;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (accept) begin
            state_q   <= SEND;
            shreg_q   <= frame;
            bit_cnt_q <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        SEND: begin
          // tx lags the shift register by one cycle, giving the 1-cycle accept latency.
          tx_q <= shreg_q[0];
          if (tick) begin
            shreg_q <= {1'b1, shreg_q[FrameW-1:1]};
            if (bit_cnt_q == LastBit) begin
              state_q   <= IDLE;
              bit_cnt_q <= '0;
              ready_q   <= 1'b1;
              busy_q    <= 1'b0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_if.ready = ready_q;
  assign tx_o       = tx_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_mvm_uart_tx.sv
// Randomised and directed checks of mvm_uart_tx against a mid-bit sampling UART receiver model.
module tb_mvm_uart_tx;
  import mvm_uart_pkg::*;

  localparam int unsigned CPP  = 4;
  localparam int unsigned BPW  = BITS_PER_WORD;
  localparam int unsigned P    = PACKET_SIZE_TX;
  localparam int unsigned NW   = N_WORDS_Y;
  localparam int unsigned XFER = NW * P * CPP;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx;
  logic busy;

  mvm_uart_tx_if #(.W_BUS(W_BUS_Y)) s_if ();

  mvm_uart_tx #(
    .CLOCKS_PER_PULSE(CPP)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .s_if  (s_if),
    .tx_o  (tx),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int rx_bytes = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Receiver: detect start edge, then sample every bit near its middle.
  initial begin
    bit         active;
    int         cnt;
    int         j;
    logic [7:0] sh;
    active = 1'b0;
    cnt    = 0;
    sh     = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 1'b0;
      end else if (!active) begin
        if (tx === 1'b0) begin
          active = 1'b1;
          cnt    = 0;
        end
      end else begin
        cnt++;
        if (cnt >= CPP / 2 && (cnt - CPP / 2) % CPP == 0) begin
          j = (cnt - CPP / 2) / CPP;
          if (j == 0) check("start_bit", {31'b0, tx}, 32'd0);
          else if (j <= BPW) sh[j-1] = tx;
          else check("pad_bit", {31'b0, tx}, 32'd1);
          if (j == P - 1) begin
            active = 1'b0;
            rx_bytes++;
            if (exp_q.size() == 0) check("extra_byte", {24'b0, sh}, 32'hFFFF_FFFF);
            else check("byte", {24'b0, sh}, {24'b0, exp_q.pop_front()});
          end
        end
      end
    end
  end

  // Waits for ready, lets the next edge accept, and records the bytes the line must carry.
  task automatic send(input logic [15:0] d, input bit hold, output int waited,
                      output logic busy_at_ready);
    int n;
    n = 0;
    s_if.data  = d;
    s_if.valid = 1'b1;
    while (s_if.ready !== 1'b1 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 400) check("ready_timeout", 32'd0, 32'd1);
    waited        = n;
    busy_at_ready = busy;
    @(posedge clk);
    exp_q.push_back(d[7:0]);
    exp_q.push_back(d[15:8]);
    #1;
    if (!hold) s_if.valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_timeout", {31'b0, n < 1000}, 32'd1);
  endtask

  initial begin
    int         w;
    int         n;
    int         rx0;
    logic       b;
    logic [15:0] d;

    s_if.valid = 1'b0;
    s_if.data  = '0;

    // Held in reset: requests must be ignored and outputs stay at idle values.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      s_if.valid = (i % 2) != 0;
      s_if.data  = 16'hFFFF;
      check("rst_tx", {31'b0, tx}, 32'd1);
      check("rst_ready", {31'b0, s_if.ready}, 32'd1);
      check("rst_busy", {31'b0, busy}, 32'd0);
    end
    s_if.valid = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_no_accept", {31'b0, busy}, 32'd0);
    check("rst_no_bytes", rx_bytes, 32'd0);

    // Single transfer: latency, timing of s_ready return, bytes via receiver.
    send(16'hA53C, 1'b0, w, b);
    check("acc_tx_still_high", {31'b0, tx}, 32'd1);
    check("acc_ready_drop", {31'b0, s_if.ready}, 32'd0);
    check("acc_busy", {31'b0, busy}, 32'd1);
    @(posedge clk);
    #1;
    check("start_latency", {31'b0, tx}, 32'd0);
    n = 1;
    while (s_if.ready !== 1'b1 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("ready_return", n, XFER);
    check("busy_clear", {31'b0, busy}, 32'd0);
    wait_idle();

    // Back-to-back with s_valid held high.
    send(16'h0102, 1'b1, w, b);
    send(16'hFFFF, 1'b0, w, b);
    check("b2b_wait", w, XFER);
    check("b2b_idle_gap", {31'b0, b}, 32'd0);
    check("b2b_busy2", {31'b0, busy}, 32'd1);
    wait_idle();

    // Busy-ignore: new data and a valid pulse during a transfer have no effect.
    rx0 = rx_bytes;
    send(16'h6C93, 1'b0, w, b);
    repeat (20) @(posedge clk);
    #1;
    s_if.data  = 16'h0000;
    s_if.valid = 1'b1;
    @(posedge clk);
    #1;
    s_if.valid = 1'b0;
    wait_idle();
    repeat (10) @(posedge clk);
    #1;
    check("ignore_busy", {31'b0, busy}, 32'd0);
    check("ignore_bytes", rx_bytes - rx0, 32'd2);

    // Reset during data bit 3 of word 1 (that bit is 0 for this pattern).
    rx0 = rx_bytes;
    send(16'h0012, 1'b0, w, b);
    repeat (71) @(posedge clk);
    #1;
    check("pre_rst_tx", {31'b0, tx}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_tx", {31'b0, tx}, 32'd1);
    check("async_rst_ready", {31'b0, s_if.ready}, 32'd1);
    check("async_rst_busy", {31'b0, busy}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_partial", rx_bytes - rx0, 32'd1);
    send(16'h00FF, 1'b0, w, b);
    wait_idle();
    check("rst_mid_after", rx_bytes - rx0, 32'd3);

    // Random transfers with random gaps.
    rx0 = rx_bytes;
    for (int k = 0; k < 10; k++) begin
      d = 16'($urandom);
      send(d, 1'b0, w, b);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_idle();
    check("rand_bytes", rx_bytes - rx0, 32'd20);
    check("rand_queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
